mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
// - Shares the single external memory port between instruction fetch (port I, read-only)
//   and the data/MEM stage (port D, read/write).
// - Requester side uses the fetch handshake: req held high until a one-cycle ack; data valid with ack.
// - Memory side is a variable-latency req/ack slave.
// - Adds round-robin or fixed-priority selection, a bus timeout with error reporting,
//   and one turnaround cycle per transaction.
// PARAMETERS
// - AW        32  address width
// - DW        32  data width (byte enables DW/8)
// - PRIO_D     0  0 = round-robin; 1 = port D always wins a tie
// - TIMEOUT  255  max cycles waiting for mem_ack; 0 disables the timeout
// PORTS
// - clk        in   1     clock, all state on rising edge
// - reset      in   1     asynchronous, active-low reset
// - if_req     in   1     fetch request, level, held until if_ack
// - if_addr    in   AW    fetch address, stable while if_req
// - if_ack     out  1     one-cycle completion pulse for port I
// - if_rdata   out  DW    fetch data, valid when if_ack
// - if_err     out  1     timeout flag, valid when if_ack
// - d_req      in   1     data request, level, held until d_ack
// - d_we       in   1     1 = write, 0 = read
// - d_be       in   DW/8  byte enables (writes only)
// - d_addr     in   AW    data address
// - d_wdata    in   DW    write data
// - d_ack      out  1     one-cycle completion pulse for port D
// - d_rdata    out  DW    read data, valid when d_ack (0 on writes)
// - d_err      out  1     timeout flag, valid when d_ack
// - mem_req    out  1     memory request, held until mem_ack or timeout
// - mem_we     out  1     memory write strobe
// - mem_be     out  DW/8  byte enables; all ones on reads
// - mem_addr   out  AW    memory address
// - mem_wdata  out  DW    memory write data
// - mem_ack    in   1     memory completion, one cycle
// - mem_rdata  in   DW    memory read data, valid with mem_ack
// - busy       out  1     high in any state other than IDLE
// BEHAVIOUR
// - Reset:
//   - All outputs 0; state IDLE; timeout counter 0.
//   - last_grant = D, so port I wins the first tie.
// - FSM IDLE -> GRANT -> DONE -> IDLE:
//   - IDLE: if any req, select the port and latch its addr/we/be/wdata into mem_* regs;
//     mem_req = 1 from the next cycle; go to GRANT.
//   - GRANT: mem_* held stable, counter increments each cycle.
//     - On mem_ack: register mem_rdata into the granted port's rdata, pulse its ack,
//       clear mem_req and counter, go to DONE.
//     - On counter == TIMEOUT-1 without mem_ack: pulse ack with err = 1, rdata = 0,
//       drop mem_req, go to DONE.
//   - DONE: one turnaround cycle with no grant. The served requester must drop req by
//     this cycle; go to IDLE.
// - Latency: req sampled in cycle N -> mem_req at N+1; mem_ack in cycle M -> port ack
//   and rdata at M+1; earliest next grant decision at M+2.
// - Selection:
//   - Ties: PRIO_D = 1 -> D. PRIO_D = 0 -> the port not in last_grant.
//   - last_grant updates only on the IDLE->GRANT transition.
// - mem_ack while not in GRANT is ignored. Both acks are never high in the same cycle.
// - rdata/err outputs hold their value until the next ack to the same port.
// - mem_ack and timeout in the same cycle: mem_ack wins, err = 0.
// - A request that drops while granted is not cancelled. The memory transaction completes
//   and the ack is still pulsed.
// - Asynchronous reset mid-transaction aborts immediately: mem_req = 0, no ack issued.
// - Counter width is $clog2(TIMEOUT+1); it never wraps because timeout fires first.
// STRUCTURE
// - Package ace_mem_pkg:
//   - FSM state encoding (IDLE/GRANT/DONE).
//   - Port id constants (PORT_I = 0, PORT_D = 1).
//   - Default TIMEOUT value.
// - Sub-module rr_arb2: combinational two-way picker (reqs, last_grant, PRIO_D -> grant
//   one-hot). FSM, datapath registers and counter stay in mem_arbiter.
// TESTING
// - Reset: reset = 0 mid-GRANT -> mem_req, acks and busy read 0 in the same cycle;
//   after release the first tie goes to I.
// - Single fetch: if_req = 1, if_addr = 0x100; memory acks 3 cycles after mem_req with
//   0xDEADBEEF -> mem_addr = 0x100, mem_we = 0, mem_be = 0xF; if_ack one cycle,
//   if_rdata = 0xDEADBEEF, if_err = 0.
// - Write: d_req, d_we = 1, d_be = 0x3, d_addr = 0x2000, d_wdata = 0x1234 -> mem_* mirror
//   these values; d_ack pulses, d_rdata = 0.
// - Tie, PRIO_D = 0: if_req and d_req held continuously -> grants alternate I, D, I, D,
//   with one DONE cycle between them.
// - Tie, PRIO_D = 1: both held -> D granted first; I is granted once d_req drops.
// - Timeout, TIMEOUT = 4, memory never acks: mem_req high 4 cycles then 0; d_ack = 1 with
//   d_err = 1, d_rdata = 0. A later mem_ack in IDLE is ignored.

Source files
------------

// File: rtl/ace_mem_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// FSM encoding, requester port ids and the default bus timeout.
package ace_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for the arbiter: fetch port, data port and memory port.
// master = arbiter side, slave = requesters plus memory.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic              if_req;
  logic [AW-1:0]     if_addr;
  logic              if_ack;
  logic [DW-1:0]     if_rdata;
  logic              if_err;
  logic              d_req;
  logic              d_we;
  logic [DW/8-1:0]   d_be;
  logic [AW-1:0]     d_addr;
  logic [DW-1:0]     d_wdata;
  logic              d_ack;
  logic [DW-1:0]     d_rdata;
  logic              d_err;
  logic              mem_req;
  logic              mem_we;
  logic [DW/8-1:0]   mem_be;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_ack;
  logic [DW-1:0]     mem_rdata;
  logic              busy;

  modport master (
    input  if_req, if_addr,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    input  mem_ack, mem_rdata,
    output if_ack, if_rdata, if_err,
    output d_ack, d_rdata, d_err,
    output mem_req, mem_we, mem_be,
    output mem_addr, mem_wdata, busy
  );

  modport slave (
    output if_req, if_addr,
    output d_req, d_we, d_be, d_addr, d_wdata,
    output mem_ack, mem_rdata,
    input  if_ack, if_rdata, if_err,
    input  d_ack, d_rdata, d_err,
    input  mem_req, mem_we, mem_be,
    input  mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way combinational picker for the memory arbiter.
// Ties go to D under PRIO_D, otherwise to the port not granted last.
module rr_arb2
  import ace_mem_pkg::*;
#(
  parameter int PRIO_D = 0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  logic pick_d;

  always_comb begin
    pick_d = 1'b0;
    unique case (1'b1)
      (req == 2'b11):
        pick_d = (PRIO_D != 0) || (last_grant == PORT_I);
      (req == 2'b10):
        pick_d = 1'b1;
      default:
        pick_d = 1'b0;
    endcase
    gnt         = 2'b00;
    gnt[PORT_D] = pick_d;
    gnt[PORT_I] = req[PORT_I] & ~pick_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (I) and data (D) requesters.
// IDLE -> GRANT -> DONE, with bus timeout and registered acks.
module mem_arbiter
  import ace_mem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int PRIO_D  = 0,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  localparam int BW = DW / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TL = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = TL[CW-1:0];
  localparam bit TO_EN = (TIMEOUT > 0);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            sel_q, sel_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [BW-1:0]   mem_be_q, mem_be_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            if_ack_q, if_ack_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic            if_err_q, if_err_d;
  logic            d_ack_q, d_ack_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            d_err_q, d_err_d;
  logic [1:0]      gnt;
  logic            timeout;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;

  rr_arb2 #(
    .PRIO_D(PRIO_D)
  ) u_pick (
    .req       ({bus.d_req, bus.if_req}),
    .last_grant(last_q),
    .gnt       (gnt)
  );

  assign timeout = TO_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    sel_d       = sel_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    if_err_d    = if_err_q;
    d_ack_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_err_d     = d_err_q;
    // Writes and timeouts both return zero data.
    rsp_err     = ~bus.mem_ack;
    rsp_data    = (bus.mem_ack && !mem_we_q) ? bus.mem_rdata : '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          state_d   = ST_GRANT;
          mem_req_d = 1'b1;
          cnt_d     = '0;
          sel_d     = gnt[PORT_D];
          last_d    = gnt[PORT_D];
          if (gnt[PORT_D]) begin
            mem_we_d    = bus.d_we;
            mem_be_d    = bus.d_we ? bus.d_be : '1;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_be_d    = '1;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
          end
        end
      end
      ST_GRANT: begin
        if (bus.mem_ack || timeout) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          cnt_d     = '0;
          if (sel_q == PORT_D) begin
            d_ack_d   = 1'b1;
            d_rdata_d = rsp_data;
            d_err_d   = rsp_err;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = rsp_data;
            if_err_d   = rsp_err;
          end
        end else if (TO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= PORT_D;
      sel_q       <= PORT_I;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_err    = if_err_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_err     = d_err_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
